// File: rtl/axi_rd_arbiter_if.sv
// axi_rd_arbiter_if: single-beat AXI read address/data channel bundle
interface axi_rd_arbiter_if;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rlast;
    logic        rready;
    modport master (output araddr, arvalid, rready, input arready, rdata, rresp, rvalid, rlast);
    modport slave (input araddr, arvalid, rready, output arready, rdata, rresp, rvalid, rlast);
endinterface

// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: round-robin arbiter sharing one single-beat AXI read slave between two masters
module axi_rd_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input logic clk,
    input logic rst,
    axi_rd_arbiter_if.slave m0,
    axi_rd_arbiter_if.slave m1,
    axi_rd_arbiter_if.master s
);
    typedef enum logic [2:0] {IDLE, ADDR, DATA, ERR, DRAIN} state_t;
    localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);
    state_t      state;
    logic [7:0]  cnt;
    logic [31:0] addr;
    logic        last_grant, grant, win, g_rready;
    logic        fwd0, fwd1, err0, err1;

    // On a tie the master not served last wins, otherwise whoever is asking
    always_comb begin
        win = (m0.arvalid && m1.arvalid) ? !last_grant : m1.arvalid;
        g_rready = grant ? m1.rready : m0.rready;
        fwd0 = state == DATA && !grant;
        fwd1 = state == DATA && grant;
        err0 = state == ERR && !grant;
        err1 = state == ERR && grant;
    end

    // Address channels; arready comes only from state and arvalid, never from rready
    always_comb begin
        m0.arready = state == IDLE && m0.arvalid && !win;
        m1.arready = state == IDLE && m1.arvalid && win;
        s.araddr = addr;
        s.arvalid = state == ADDR;
        s.rready = (state == DATA && g_rready) || state == DRAIN;
    end

    // Read channels: slave beat goes to the granted master only, ERR fabricates a SLVERR beat
    always_comb begin
        m0.rvalid = (fwd0 && s.rvalid) || err0;
        m0.rdata = fwd0 ? s.rdata : '0;
        m0.rresp = fwd0 ? s.rresp : err0 ? 2'b10 : 2'b00;
        m0.rlast = (fwd0 && s.rlast) || err0;
        m1.rvalid = (fwd1 && s.rvalid) || err1;
        m1.rdata = fwd1 ? s.rdata : '0;
        m1.rresp = fwd1 ? s.rresp : err1 ? 2'b10 : 2'b00;
        m1.rlast = (fwd1 && s.rlast) || err1;
    end

    // Transaction FSM; the timeout counts only DATA cycles with no slave beat
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            last_grant <= 1'b1;
            grant <= 1'b0;
            addr <= '0;
        end else begin
            case (state)
                IDLE: if (m0.arvalid || m1.arvalid) begin
                    addr <= win ? m1.araddr : m0.araddr;
                    grant <= win;
                    state <= ADDR;
                end
                ADDR: if (s.arready) begin
                    cnt <= '0;
                    state <= DATA;
                end
                DATA: if (s.rvalid) begin
                    if (g_rready) begin
                        last_grant <= grant;
                        state <= IDLE;
                    end
                end else begin
                    cnt <= cnt + 8'd1;
                    if (cnt == LIMIT) state <= ERR;
                end
                ERR: if (g_rready) state <= DRAIN;
                DRAIN: if (s.rvalid) begin
                    last_grant <= grant;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb_axi_rd_arbiter: scoreboard bench for the two-master AXI read arbiter
module tb_axi_rd_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axi_rd_arbiter_if m0();
    axi_rd_arbiter_if m1();
    axi_rd_arbiter_if s();

    axi_rd_arbiter #(.TIMEOUT(8)) dut (.clk(clk), .rst(rst), .m0(m0), .m1(m1), .s(s));

    typedef struct {int id; logic [63:0] data; logic [1:0] resp; logic last;} rsp_t;
    typedef struct {int ard; int rd; logic [63:0] data; logic [1:0] resp;} sl_t;

    rsp_t        exp_q[$];
    sl_t         sl_q[$];
    logic [31:0] addr_q[$];
    int          passed = 0;
    int          total = 0;
    bit          sl_busy = 1'b0;

    task automatic chk(input string n, input logic [159:0] act, input logic [159:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, required %0h", n, act, exp);
    endtask

    task automatic bad(input string n, input logic [63:0] act, input string need);
        total++;
        $display("FAIL %s: got %0h, required %s", n, act, need);
    endtask

    task automatic mon(input int k, input logic v, input logic r, input logic [63:0] d,
                       input logic [1:0] rs, input logic l);
        rsp_t e;
        if (!v) return;
        if (exp_q.size() == 0 || exp_q[0].id != k) begin
            bad($sformatf("r_unexpected_m%0d", k), d, "no rvalid");
            return;
        end
        if (!r) return;
        e = exp_q.pop_front();
        chk($sformatf("r_beat_m%0d", k), {d, rs, l}, {e.data, e.resp, e.last});
    endtask

    // Address monitor
    always @(negedge clk) begin
        if (!rst && s.arvalid && s.arready) begin
            if (addr_q.size() == 0) bad("ar_unexpected", {32'h0, s.araddr}, "no slave request");
            else chk("ar_addr", s.araddr, addr_q.pop_front());
        end
    end

    // Read-data monitor
    always @(negedge clk) begin
        if (!rst) begin
            mon(0, m0.rvalid, m0.rready, m0.rdata, m0.rresp, m0.rlast);
            mon(1, m1.rvalid, m1.rready, m1.rdata, m1.rresp, m1.rlast);
        end
    end

    // Slave model: replies with the next queued behaviour, abandons on reset
    initial begin
        sl_t e;
        bit  ab;
        s.arready = 0; s.rvalid = 0; s.rdata = 0; s.rresp = 0; s.rlast = 0;
        forever begin
            @(negedge clk);
            if (!rst && s.arvalid && sl_q.size() != 0) begin
                e = sl_q.pop_front();
                ab = 0;
                sl_busy = 1;
                repeat (e.ard) @(posedge clk);
                #1 s.arready = 1;
                @(posedge clk);
                #1 s.arready = 0;
                for (int i = 1; i < e.rd && !ab; i++) begin
                    @(posedge clk);
                    ab = rst;
                end
                if (!ab) begin
                    #1 s.rvalid = 1; s.rdata = e.data; s.rresp = e.resp; s.rlast = 1;
                    for (int i = 0; i < 400; i++) begin
                        @(negedge clk);
                        if (s.rready) break;
                    end
                    @(posedge clk);
                    #1 s.rvalid = 0; s.rdata = 0; s.rresp = 0; s.rlast = 0;
                end
                sl_busy = 0;
            end
        end
    end

    task automatic req(input int k, input logic [31:0] a);
        bit ok = 0;
        @(posedge clk);
        #1;
        if (k != 0) begin m1.araddr = a; m1.arvalid = 1; end
        else begin m0.araddr = a; m0.arvalid = 1; end
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            ok = (k != 0) ? m1.arready : m0.arready;
        end
        if (!ok) bad($sformatf("ar_timeout_m%0d", k), {32'h0, a}, "arready");
        @(posedge clk);
        #1;
        if (k != 0) m1.arvalid = 0; else m0.arvalid = 0;
    endtask

    task automatic xact(input int k, input logic [31:0] a, input logic [63:0] d,
                        input int ard, input int rd, input logic [1:0] rs);
        addr_q.push_back(a);
        sl_q.push_back('{ard, rd, d, rs});
        exp_q.push_back('{k, d, rs, 1'b1});
    endtask

    task automatic wait_done();
        int i = 0;
        while ((exp_q.size() != 0 || sl_q.size() != 0 || sl_busy) && i < 400) begin
            @(negedge clk);
            i++;
        end
        if (i >= 400) bad("drain_timeout", 64'(exp_q.size()), "empty scoreboard");
        repeat (2) @(negedge clk);
    endtask

    // Negedges from the slave address handshake until master k first sees rvalid
    task automatic lat(input int k, output int n);
        int i = 0;
        do begin @(negedge clk); i++; end while (!(s.arvalid && s.arready) && i < 100);
        n = 0;
        do begin @(negedge clk); n++; end while (!((k != 0) ? m1.rvalid : m0.rvalid) && n < 100);
    endtask

    task automatic chk_idle(input string n);
        chk(n, {m0.rvalid, m1.rvalid, m0.rlast, m1.rlast, m0.rresp, m1.rresp,
                m0.arready, m1.arready, s.arvalid, s.rready, m0.rdata, m1.rdata}, '0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int i;
        m0.arvalid = 0; m0.araddr = 0; m0.rready = 1;
        m1.arvalid = 0; m1.araddr = 0; m1.rready = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk_idle("reset_outputs");

        // first tie after reset goes to m0, then alternation continues
        xact(0, 32'h8000_0000, 64'hAAAA_0000_0000_0001, 1, 2, 2'b00);
        xact(1, 32'h8000_0100, 64'hBBBB_0000_0000_0002, 1, 2, 2'b01);
        fork
            req(0, 32'h8000_0000);
            req(1, 32'h8000_0100);
        join
        wait_done();
        xact(0, 32'h8000_0200, 64'hAAAA_0000_0000_0003, 2, 1, 2'b00);
        xact(1, 32'h8000_0300, 64'hBBBB_0000_0000_0004, 1, 3, 2'b00);
        fork
            req(0, 32'h8000_0200);
            req(1, 32'h8000_0300);
        join
        wait_done();

        // single m0 read, arready after 2 cycles, data 3 cycles later
        xact(0, 32'h0200_0000, 64'h0000_0000_0000_1234, 2, 3, 2'b00);
        req(0, 32'h0200_0000);
        lat(0, n);
        chk("basic_latency", 160'(n), 160'd3);
        wait_done();

        // m1 timeout: ERR beat after 8 empty DATA cycles, late beat drained
        addr_q.push_back(32'h0200_4000);
        sl_q.push_back('{1, 14, 64'hDEAD_BEEF_DEAD_BEEF, 2'b00});
        exp_q.push_back('{1, 64'h0, 2'b10, 1'b1});
        req(1, 32'h0200_4000);
        lat(1, n);
        chk("timeout_latency", 160'(n), 160'd9);
        wait_done();

        // beat arriving on the threshold cycle wins over the timeout
        xact(0, 32'h0200_8000, 64'hCAFE_F00D_0000_0008, 1, 8, 2'b00);
        req(0, 32'h0200_8000);
        lat(0, n);
        chk("threshold_latency", 160'(n), 160'd8);
        wait_done();

        // master back-pressure: s_rready follows m0_rready, data held
        m0.rready = 0;
        xact(0, 32'h0200_C000, 64'h0123_4567_89AB_CDEF, 1, 2, 2'b00);
        req(0, 32'h0200_C000);
        i = 0;
        do begin @(negedge clk); i++; end while (!m0.rvalid && i < 100);
        for (int j = 0; j < 5; j++) begin
            if (j != 0) @(negedge clk);
            chk($sformatf("stall_%0d", j), {s.rready, m0.rvalid, m0.rdata},
                {1'b0, 1'b1, 64'h0123_4567_89AB_CDEF});
        end
        @(posedge clk);
        #1 m0.rready = 1;
        wait_done();

        // reset in DATA abandons the read; last_grant returns to m0-first
        addr_q.push_back(32'h0201_0000);
        sl_q.push_back('{1, 10, 64'h5555_5555_5555_5555, 2'b00});
        req(0, 32'h0201_0000);
        i = 0;
        do begin @(negedge clk); i++; end while (!(s.arvalid && s.arready) && i < 100);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1;
        @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk_idle("reset_mid_data");
        xact(0, 32'h0202_0000, 64'h0000_0000_0000_00A0, 1, 2, 2'b00);
        xact(1, 32'h0202_0100, 64'h0000_0000_0000_00B1, 1, 2, 2'b00);
        fork
            req(0, 32'h0202_0000);
            req(1, 32'h0202_0100);
        join
        wait_done();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
